// File: rtl/restoring_divider_if.sv
// Handshake and operand bundle for restoring_divider.
// When DIV_SIGNED_EN is defined the bundle also carries signed_op.
interface restoring_divider_if #(parameter int WIDTH = 16);
    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
`ifdef DIV_SIGNED_EN
    logic                 signed_op;
`endif
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
`ifdef DIV_SIGNED_EN
        output signed_op,
`endif
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
`ifdef DIV_SIGNED_EN
        input  signed_op,
`endif
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider: 2*WIDTH / WIDTH, one quotient bit per clock.
// Optional macro DIV_SIGNED_EN adds two's-complement division selected by signed_op.
module restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    restoring_divider_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
    typedef enum logic [1:0] {EX_NONE = 2'd0, EX_ZERO = 2'd1, EX_OVF = 2'd2} early_t;

    state_t             state_q, state_d;
    early_t             early_q, early_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   shq_q, shq_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;
`ifdef DIV_SIGNED_EN
    logic               sop_q, sop_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
`endif

    logic [2*WIDTH-1:0] num_mag;
    logic [WIDTH-1:0]   den_mag;
    logic [WIDTH+1:0]   shifted;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   shq_next;
    logic [WIDTH-1:0]   fin_quot;
    logic [WIDTH-1:0]   fin_rem;
    logic               fin_ovf;

    // The unsigned datapath always works on operand magnitudes.
    always_comb begin
        num_mag = bus.dividend;
        den_mag = bus.divisor;
`ifdef DIV_SIGNED_EN
        if (bus.signed_op) begin
            if (bus.dividend[2*WIDTH-1]) num_mag = -bus.dividend;
            if (bus.divisor[WIDTH-1])    den_mag = -bus.divisor;
        end
`endif
    end

    always_comb begin
        shifted  = {rem_q, shq_q[WIDTH-1]};
        trial    = shifted[WIDTH:0] - {1'b0, dvsr_q};
        qbit     = (shifted >= {2'b00, dvsr_q});
        rem_next = qbit ? trial : shifted[WIDTH:0];
        shq_next = {shq_q[WIDTH-2:0], qbit};
    end

    // Sign fix-up and range check applied on the final iteration.
    always_comb begin
        fin_quot = shq_next;
        fin_rem  = rem_next[WIDTH-1:0];
        fin_ovf  = 1'b0;
`ifdef DIV_SIGNED_EN
        if (sop_q) begin
            if (qneg_q) begin
                fin_ovf  = (shq_next > HALF);
                fin_quot = -shq_next;
            end else begin
                fin_ovf  = (shq_next > (HALF - 1'b1));
            end
            if (rneg_q) fin_rem = -rem_next[WIDTH-1:0];
        end
`endif
        if (fin_ovf) begin
            fin_quot = '1;
            fin_rem  = low_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            early_q     <= EX_NONE;
            count_q     <= '0;
            rem_q       <= '0;
            shq_q       <= '0;
            dvsr_q      <= '0;
            low_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            sop_q       <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            early_q     <= early_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            shq_q       <= shq_d;
            dvsr_q      <= dvsr_d;
            low_q       <= low_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
`ifdef DIV_SIGNED_EN
            sop_q       <= sop_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    // Zero-divisor and unsigned-overflow cases are classified at accept but
    // pass through one RUN cycle, so their results enter FIN one edge later.
    always_comb begin
        state_d     = state_q;
        early_d     = early_q;
        count_d     = count_q;
        rem_d       = rem_q;
        shq_d       = shq_q;
        dvsr_d      = dvsr_q;
        low_d       = low_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
`ifdef DIV_SIGNED_EN
        sop_d       = sop_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    count_d = '0;
                    rem_d   = {1'b0, num_mag[2*WIDTH-1:WIDTH]};
                    shq_d   = num_mag[WIDTH-1:0];
                    dvsr_d  = den_mag;
                    low_d   = bus.dividend[WIDTH-1:0];
                    if (den_mag == '0) begin
                        early_d = EX_ZERO;
                    end else if (num_mag[2*WIDTH-1:WIDTH] >= den_mag) begin
                        early_d = EX_OVF;
                    end else begin
                        early_d = EX_NONE;
                    end
`ifdef DIV_SIGNED_EN
                    sop_d  = bus.signed_op;
                    qneg_d = bus.signed_op & (bus.dividend[2*WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    rneg_d = bus.signed_op & bus.dividend[2*WIDTH-1];
`endif
                end
            end
            RUN: begin
                if (early_q != EX_NONE) begin
                    state_d     = FIN;
                    quotient_d  = '1;
                    remainder_d = low_q;
                    dbz_d       = (early_q == EX_ZERO);
                    ovf_d       = (early_q == EX_OVF);
                end else begin
                    rem_d   = rem_next;
                    shq_d   = shq_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_d     = FIN;
                        quotient_d  = fin_quot;
                        remainder_d = fin_rem;
                        dbz_d       = 1'b0;
                        ovf_d       = fin_ovf;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.busy        = (state_q != IDLE);
        bus.done        = (state_q == FIN);
        bus.quotient    = quotient_q;
        bus.remainder   = remainder_q;
        bus.div_by_zero = dbz_q;
        bus.overflow    = ovf_q;
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed table, mid-operation
// sequences and randomized operations against an arithmetic reference model.
module tb_restoring_divider;

    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dd;
        logic [15:0] dv;
        bit          sop;
        logic [15:0] q;
        logic [15:0] r;
        bit          dbz;
        bit          ovf;
        int          lat;
    } vec_t;

    int n_compared = 0;
    int n_failed   = 0;

    logic [15:0] got_q, got_r;
    bit          got_dbz, got_ovf, busy_ok, done_after, busy_after;
    int          got_lat;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer division with the divider's reporting rules.
    function automatic void model(input logic [31:0] dd, input logic [15:0] dv, input bit sop,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output bit dbz, output bit ovf, output int lat);
        longint n, d, qq, rr, qm;
        dbz = 1'b0;
        ovf = 1'b0;
        q   = 16'hFFFF;
        r   = dd[15:0];
        lat = 1;
        if (dv == 16'd0) begin
            dbz = 1'b1;
            return;
        end
        if (sop) begin
            n = longint'(signed'(dd));
            d = longint'(signed'(dv));
        end else begin
            n = longint'({32'd0, dd});
            d = longint'({48'd0, dv});
        end
        qq = n / d;
        rr = n % d;
        qm = (qq < 0) ? -qq : qq;
        if (qm > 65535) begin
            ovf = 1'b1;
            return;
        end
        lat = WIDTH;
        if (sop && (qq > 32767 || qq < -32768)) begin
            ovf = 1'b1;
            return;
        end
        q = qq[15:0];
        r = rr[15:0];
    endfunction

    // Starts one operation and follows it to its done pulse. poke_at >= 0 pulses
    // start with unrelated operands in that cycle of the operation.
    task automatic apply_stimulus(input logic [31:0] dd, input logic [15:0] dv, input bit sop,
                                  input int poke_at);
        int k;
        k = 0;
        while (bus.busy && k < 64) begin
            @(negedge clk);
            k++;
        end
        check_output("idle_before_start", {63'd0, bus.busy}, 64'd0);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
`ifdef DIV_SIGNED_EN
        bus.signed_op = sop;
`else
        if (sop) $display("[TB] signed vector skipped in unsigned build");
`endif
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_ok = 1'b1;
        got_lat = 0;
        @(negedge clk);
        while (!bus.done && got_lat < WIDTH + 8) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (got_lat == poke_at) begin
                bus.start    = 1'b1;
                bus.dividend = 32'd50;
                bus.divisor  = 16'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            got_lat++;
        end
        bus.start = 1'b0;
        if (!bus.busy) busy_ok = 1'b0;
        got_q   = bus.quotient;
        got_r   = bus.remainder;
        got_dbz = bus.div_by_zero;
        got_ovf = bus.overflow;
        @(negedge clk);
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    task automatic verify(input string tag, input logic [15:0] q, input logic [15:0] r,
                          input bit dbz, input bit ovf, input int lat);
        check_output({tag, " quotient"},    {48'd0, got_q}, {48'd0, q});
        check_output({tag, " remainder"},   {48'd0, got_r}, {48'd0, r});
        check_output({tag, " div_by_zero"}, {63'd0, got_dbz}, {63'd0, dbz});
        check_output({tag, " overflow"},    {63'd0, got_ovf}, {63'd0, ovf});
        check_output({tag, " latency"},     64'(got_lat), 64'(lat));
        check_output({tag, " busy_held"},   {63'd0, busy_ok}, 64'd1);
        check_output({tag, " done_pulse"},  {63'd0, done_after}, 64'd0);
        check_output({tag, " busy_clear"},  {63'd0, busy_after}, 64'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [15:0] mq, mr;
        bit          mdbz, movf;
        int          mlat, k, done_seen;
        logic [31:0] a, b, rr, dd;
        logic [15:0] dv;

        vecs.push_back('{32'd100,        16'd7,      1'b0, 16'd14,   16'd2,      1'b0, 1'b0, WIDTH});
        vecs.push_back('{32'h0001_2345,  16'd0,      1'b0, 16'hFFFF, 16'h2345,   1'b1, 1'b0, 1});
        vecs.push_back('{32'h0005_0000,  16'd5,      1'b0, 16'hFFFF, 16'h0000,   1'b0, 1'b1, 1});
        vecs.push_back('{32'h0004_FFFF,  16'd5,      1'b0, 16'hFFFF, 16'd4,      1'b0, 1'b0, WIDTH});
        vecs.push_back('{32'd1000,       16'd10,     1'b0, 16'd100,  16'd0,      1'b0, 1'b0, WIDTH});
        vecs.push_back('{32'd7,          16'd100,    1'b0, 16'd0,    16'd7,      1'b0, 1'b0, WIDTH});
        vecs.push_back('{32'hFFFE_FFFF,  16'hFFFF,   1'b0, 16'hFFFF, 16'hFFFE,   1'b0, 1'b0, WIDTH});
        vecs.push_back('{32'hFFFF_FFFF,  16'hFFFF,   1'b0, 16'hFFFF, 16'hFFFF,   1'b0, 1'b1, 1});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{32'hFFFF_FF9C,  16'd7,      1'b1, 16'hFFF2, 16'hFFFE,   1'b0, 1'b0, WIDTH});
        vecs.push_back('{32'hFFFF_0000,  16'hFFFF,   1'b1, 16'hFFFF, 16'h0000,   1'b0, 1'b1, 1});
        vecs.push_back('{32'hFFFF_8000,  16'd1,      1'b1, 16'h8000, 16'h0000,   1'b0, 1'b0, WIDTH});
        vecs.push_back('{32'h0000_8000,  16'd1,      1'b1, 16'hFFFF, 16'h8000,   1'b0, 1'b1, WIDTH});
        vecs.push_back('{32'd100,        16'hFFF9,   1'b0, 16'd0,    16'd100,    1'b0, 1'b0, WIDTH});
`endif

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIV_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset busy",        {63'd0, bus.busy}, 64'd0);
        check_output("reset done",        {63'd0, bus.done}, 64'd0);
        check_output("reset quotient",    {48'd0, bus.quotient}, 64'd0);
        check_output("reset remainder",   {48'd0, bus.remainder}, 64'd0);
        check_output("reset div_by_zero", {63'd0, bus.div_by_zero}, 64'd0);
        check_output("reset overflow",    {63'd0, bus.overflow}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].dd, vecs[i].dv, vecs[i].sop, -1);
            verify($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, vecs[i].lat);
        end

        // start pulsed mid-run must be ignored and not queued
        apply_stimulus(32'd100, 16'd7, 1'b0, 5);
        verify("start_in_run", 16'd14, 16'd2, 1'b0, 1'b0, WIDTH);

        // reset at iteration 8 discards the operation
        bus.start    = 1'b1;
        bus.dividend = 32'd5000;
        bus.divisor  = 16'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("midreset busy",      {63'd0, bus.busy}, 64'd0);
        check_output("midreset quotient",  {48'd0, bus.quotient}, 64'd0);
        check_output("midreset remainder", {48'd0, bus.remainder}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 24; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        check_output("midreset no_done", 64'(done_seen), 64'd0);
        apply_stimulus(32'd1000, 16'd10, 1'b0, -1);
        verify("after_reset", 16'd100, 16'd0, 1'b0, 1'b0, WIDTH);

        // start held high: re-accepted in the first IDLE cycle
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 16'd7;
        @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!bus.done && k < WIDTH + 8) begin
            @(negedge clk);
            k++;
        end
        check_output("held latency", 64'(k), 64'(WIDTH));
        @(negedge clk);
        check_output("held idle_gap", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        check_output("held reaccept", {63'd0, bus.busy}, 64'd1);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < WIDTH + 8) begin
            @(negedge clk);
            k++;
        end
        check_output("held quotient", {48'd0, bus.quotient}, 64'd14);
        @(negedge clk);

        // multiplier round trip
        for (int i = 0; i < 200; i++) begin
            a  = 32'($urandom_range(0, 65535));
            b  = 32'($urandom_range(1, 65535));
            rr = 32'($urandom_range(0, int'(b) - 1));
            dd = a * b + rr;
            apply_stimulus(dd, b[15:0], 1'b0, -1);
            verify($sformatf("rt%0d", i), a[15:0], rr[15:0], 1'b0, 1'b0, WIDTH);
        end

        // unconstrained operands against the reference model
        for (int i = 0; i < 60; i++) begin
            dd = {16'($urandom_range(0, 65535) >> $urandom_range(0, 16)), 16'($urandom_range(0, 65535))};
            dv = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            model(dd, dv, 1'b0, mq, mr, mdbz, movf, mlat);
            apply_stimulus(dd, dv, 1'b0, -1);
            verify($sformatf("rnd%0d", i), mq, mr, mdbz, movf, mlat);
        end

`ifdef DIV_SIGNED_EN
        for (int i = 0; i < 60; i++) begin
            dd = 32'($urandom);
            if ($urandom_range(0, 1) == 1) dd = 32'(signed'(dd[23:0]));
            dv = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            model(dd, dv, 1'b1, mq, mr, mdbz, movf, mlat);
            apply_stimulus(dd, dv, 1'b1, -1);
            verify($sformatf("srnd%0d", i), mq, mr, mdbz, movf, mlat);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
